// File: rtl/pacman_pkg.sv
// Shared game types and constants for the pacman slice.
// Holds the game state encoding, keycodes and output flag helpers.
package pacman_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        POWER = 3'd2,
        DEATH = 3'd3,
        WIN   = 3'd4,
        LOSE  = 3'd5
    } game_state_t;

    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;

    typedef struct packed {
        logic start;
        logic freeze;
        logic ggshow;
        logic win;
    } flags_t;

    // Level outputs that follow directly from the state being entered.
    function automatic flags_t flags_of(game_state_t s);
        flags_t f;
        f.start  = (s == PLAY) || (s == POWER);
        f.freeze = (s == POWER);
        f.ggshow = (s == LOSE);
        f.win    = (s == WIN);
        return f;
    endfunction

    function automatic logic is_move_key(logic [7:0] k);
        return (k == KEY_W) || (k == KEY_A) ||
               (k == KEY_S) || (k == KEY_D);
    endfunction

    function automatic int max_int(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Game-flow bus between sprite/score logic and the game controller.
// master: the controller (consumes gg/sd_show/score/keycode, drives flow).
interface game_ctrl_if;

    logic [7:0] keycode;
    logic [3:0] gg;
    logic [3:0] sd_show;
    logic [7:0] score;

    logic       start;
    logic       freeze;
    logic       round_reset;
    logic       game_reset;
    logic [2:0] lives;
    logic [2:0] state;
    logic       ggShow;
    logic       win;

    modport master (
        input  keycode, gg, sd_show, score,
        output start, freeze, round_reset, game_reset,
        output lives, state, ggShow, win
    );

    modport slave (
        output keycode, gg, sd_show, score,
        input  start, freeze, round_reset, game_reset,
        input  lives, state, ggShow, win
    );

endinterface

// File: rtl/frame_tick.sv
// Synchronises the raw VGA vsync level into the Clk domain.
// Ports: Clk, Reset_n, frame_clk (raw level) -> tick (1-Clk pulse per frame).
module frame_tick (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic tick
);

    // [0],[1]: synchroniser; [2]: previous synchronised level.
    logic [2:0] sync;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync <= '0;
            tick <= 1'b0;
        end else begin
            sync <= {sync[1:0], frame_clk};
            tick <= sync[1] & ~sync[2];
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Frame-timed game-flow controller: start, power freeze, death, win/lose.
// Ports: Clk, Reset_n (async low), frame_clk (raw vsync), bus (master side).
module game_ctrl
    import pacman_pkg::*;
#(
    parameter int         FREEZE_FRAMES = 300,
    parameter int         DEATH_FRAMES  = 90,
    parameter int         START_LIVES   = 3,
    parameter int         WIN_SCORE     = 200,
    parameter logic [7:0] START_KEY     = KEY_ENTER
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          frame_clk,
    game_ctrl_if.master   bus
);

    localparam int TW_RAW =
        $clog2(max_int(FREEZE_FRAMES, DEATH_FRAMES));
    localparam int TW = (TW_RAW < 1) ? 1 : TW_RAW;

    localparam logic [TW-1:0] FRZ_INIT = TW'(FREEZE_FRAMES - 1);
    localparam logic [TW-1:0] DTH_INIT = TW'(DEATH_FRAMES - 1);
    localparam logic [2:0]    LIVES0   = 3'(START_LIVES);
    localparam logic [8:0]    WIN_L    = 9'(WIN_SCORE);

    // Async assert, sync release of the internal reset.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    logic tick;

    frame_tick u_tick (
        .Clk       (Clk),
        .Reset_n   (rst_n),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    game_state_t   st;
    flags_t        fl;
    logic [TW-1:0] timer;
    logic [2:0]    lives;
    logic          round_reset;
    logic          game_reset;
    logic [3:0]    sd_q;
    logic          sd_eat;

    logic start_key;
    logic win_hit;
    logic hit;

    assign start_key = (bus.keycode == START_KEY);
    assign win_hit   = ({1'b0, bus.score} >= WIN_L);
    assign hit       = |bus.gg;

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            fl          <= '0;
            timer       <= '0;
            lives       <= LIVES0;
            round_reset <= 1'b0;
            game_reset  <= 1'b0;
            sd_q        <= '0;
            sd_eat      <= 1'b0;
        end else begin
            sd_q        <= bus.sd_show;
            sd_eat      <= |(sd_q & ~bus.sd_show);
            round_reset <= 1'b0;
            game_reset  <= 1'b0;

            case (st)
                IDLE, WIN, LOSE: begin
                    if (start_key) begin
                        st          <= PLAY;
                        fl          <= flags_of(PLAY);
                        lives       <= LIVES0;
                        timer       <= '0;
                        round_reset <= 1'b1;
                        game_reset  <= 1'b1;
                    end
                end
                PLAY: begin
                    // Eating wins over a collision in the same cycle.
                    if (win_hit) begin
                        st <= WIN;
                        fl <= flags_of(WIN);
                    end else if (sd_eat) begin
                        st    <= POWER;
                        fl    <= flags_of(POWER);
                        timer <= FRZ_INIT;
                    end else if (hit) begin
                        st    <= DEATH;
                        fl    <= flags_of(DEATH);
                        timer <= DTH_INIT;
                        if (lives != 3'd0) begin
                            lives <= lives - 1'b1;
                        end
                    end
                end
                POWER: begin
                    if (win_hit) begin
                        st <= WIN;
                        fl <= flags_of(WIN);
                    end else if (sd_eat) begin
                        timer <= FRZ_INIT;
                    end else if (tick) begin
                        if (timer == '0) begin
                            st <= PLAY;
                            fl <= flags_of(PLAY);
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                end
                DEATH: begin
                    if (tick) begin
                        if (timer != '0) begin
                            timer <= timer - 1'b1;
                        end else if (lives == 3'd0) begin
                            st <= LOSE;
                            fl <= flags_of(LOSE);
                        end else begin
                            st          <= PLAY;
                            fl          <= flags_of(PLAY);
                            round_reset <= 1'b1;
                        end
                    end
                end
                default: begin
                    st <= IDLE;
                    fl <= '0;
                end
            endcase
        end
    end

    assign bus.start       = fl.start;
    assign bus.freeze      = fl.freeze;
    assign bus.ggShow      = fl.ggshow;
    assign bus.win         = fl.win;
    assign bus.round_reset = round_reset;
    assign bus.game_reset  = game_reset;
    assign bus.lives       = lives;
    assign bus.state       = st;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: step table plus start/reset sequences.
// Frame ticks are produced by the bench driving frame_clk itself.
module tb_game_ctrl;
    import pacman_pkg::*;

    logic Clk       = 1'b0;
    logic Reset_n   = 1'b0;
    logic frame_clk = 1'b0;

    game_ctrl_if bus();

    game_ctrl dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    always #10 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;
    int rr_cnt  = 0;
    int gr_cnt  = 0;

    always @(negedge Clk) begin
        if (bus.round_reset === 1'b1) rr_cnt++;
        if (bus.game_reset === 1'b1) gr_cnt++;
    end

    typedef struct {
        logic [7:0] key;
        logic [3:0] gg;
        logic [3:0] sd;
        logic [7:0] score;
        int         clks;
        int         frames;
        logic [2:0] st;
        logic       start;
        logic       freeze;
        logic [2:0] lives;
        logic       ggs;
        logic       win;
        int         rr;
        int         gr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(logic [7:0] key, logic [3:0] gg,
                       logic [3:0] sd, logic [7:0] score,
                       int clks, int frames, logic [2:0] st,
                       logic start, logic freeze, logic [2:0] lives,
                       logic ggs, logic win, int rr, int gr);
        vec_t v;
        v.key = key; v.gg = gg; v.sd = sd; v.score = score;
        v.clks = clks; v.frames = frames; v.st = st;
        v.start = start; v.freeze = freeze; v.lives = lives;
        v.ggs = ggs; v.win = win; v.rr = rr; v.gr = gr;
        tbl.push_back(v);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic pulse(int n);
        for (int i = 0; i < n; i++) begin
            frame_clk = 1'b1;
            repeat (4) @(negedge Clk);
            frame_clk = 1'b0;
            repeat (4) @(negedge Clk);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.keycode = 8'h00;
        bus.gg      = 4'h0;
        bus.sd_show = 4'hF;
        bus.score   = 8'd0;

        //      key    gg  sd   sc  clk  frm  state  st fz lv gs wn rr gr
        add(8'h00, 0, 4'hF,   0, 3,   0, PLAY,  1, 0, 3, 0, 0, 1, 1);
        add(8'h00, 0, 4'hE,   0, 1,   0, PLAY,  1, 0, 3, 0, 0, 1, 1);
        add(8'h00, 0, 4'hE,   0, 1,   0, POWER, 1, 1, 3, 0, 0, 1, 1);
        add(8'h00, 0, 4'hE,   0, 0, 299, POWER, 1, 1, 3, 0, 0, 1, 1);
        add(8'h00, 0, 4'hE,   0, 0,   1, PLAY,  1, 0, 3, 0, 0, 1, 1);
        add(8'h00, 0, 4'hC,   0, 2,   0, POWER, 1, 1, 3, 0, 0, 1, 1);
        add(8'h00, 0, 4'hC,   0, 0, 150, POWER, 1, 1, 3, 0, 0, 1, 1);
        add(8'h00, 0, 4'h8,   0, 2,   0, POWER, 1, 1, 3, 0, 0, 1, 1);
        add(8'h00, 0, 4'h8,   0, 0, 299, POWER, 1, 1, 3, 0, 0, 1, 1);
        add(8'h00, 0, 4'h8,   0, 0,   1, PLAY,  1, 0, 3, 0, 0, 1, 1);
        add(8'h00, 0, 4'h0,   0, 2,   0, POWER, 1, 1, 3, 0, 0, 1, 1);
        add(8'h00, 2, 4'h0,   0, 2,   0, POWER, 1, 1, 3, 0, 0, 1, 1);
        add(8'h00, 0, 4'h0,   0, 0, 300, PLAY,  1, 0, 3, 0, 0, 1, 1);
        add(8'h00, 2, 4'h0,   0, 1,   0, DEATH, 0, 0, 2, 0, 0, 1, 1);
        add(8'h00, 0, 4'h0,   0, 0,  89, DEATH, 0, 0, 2, 0, 0, 1, 1);
        add(8'h00, 0, 4'h0,   0, 0,   1, PLAY,  1, 0, 2, 0, 0, 2, 1);
        add(8'h00, 2, 4'h0,   0, 1,   0, DEATH, 0, 0, 1, 0, 0, 2, 1);
        add(8'h00, 0, 4'h0,   0, 0,  90, PLAY,  1, 0, 1, 0, 0, 3, 1);
        add(8'h00, 2, 4'h0,   0, 1,   0, DEATH, 0, 0, 0, 0, 0, 3, 1);
        add(8'h00, 0, 4'h0,   0, 0,  89, DEATH, 0, 0, 0, 0, 0, 3, 1);
        add(8'h00, 0, 4'h0,   0, 0,   1, LOSE,  0, 0, 0, 1, 0, 3, 1);
        add(8'h00, 0, 4'h0,   0, 5,   3, LOSE,  0, 0, 0, 1, 0, 3, 1);
        add(8'h28, 0, 4'h0,   0, 1,   0, PLAY,  1, 0, 3, 0, 0, 4, 2);
        add(8'h28, 0, 4'h0,   0, 5,   0, PLAY,  1, 0, 3, 0, 0, 4, 2);
        add(8'h00, 0, 4'hF, 199, 3,   0, PLAY,  1, 0, 3, 0, 0, 4, 2);
        add(8'h00, 0, 4'hE, 199, 2,   0, POWER, 1, 1, 3, 0, 0, 4, 2);
        add(8'h00, 0, 4'hE, 200, 1,   0, WIN,   0, 0, 3, 0, 1, 4, 2);
        add(8'h00, 0, 4'hE,   0, 0,   2, WIN,   0, 0, 3, 0, 1, 4, 2);
        add(8'h28, 0, 4'hE,   0, 1,   0, PLAY,  1, 0, 3, 0, 0, 5, 3);
        add(8'h00, 0, 4'hC,   0, 1,   0, PLAY,  1, 0, 3, 0, 0, 5, 3);
        add(8'h00, 2, 4'hC,   0, 1,   0, POWER, 1, 1, 3, 0, 0, 5, 3);
        add(8'h00, 0, 4'hC,   0, 0, 300, PLAY,  1, 0, 3, 0, 0, 5, 3);
        add(8'h00, 0, 4'h0,   0, 1,   0, PLAY,  1, 0, 3, 0, 0, 5, 3);
        add(8'h00, 0, 4'h0, 200, 1,   0, WIN,   0, 0, 3, 0, 1, 5, 3);

        // Reset values while held in reset.
        repeat (3) @(negedge Clk);
        #1;
        chk("rst.state",  bus.state,       IDLE);
        chk("rst.lives",  bus.lives,       3);
        chk("rst.start",  bus.start,       0);
        chk("rst.freeze", bus.freeze,      0);
        chk("rst.rr",     bus.round_reset, 0);
        chk("rst.gr",     bus.game_reset,  0);
        chk("rst.ggShow", bus.ggShow,      0);
        chk("rst.win",    bus.win,         0);

        Reset_n = 1'b1;
        repeat (4) @(negedge Clk);
        #1;
        chk("idle.state", bus.state, IDLE);

        // Start: both reset pulses exactly one Clk wide.
        bus.keycode = 8'h28;
        @(negedge Clk);
        #1;
        chk("go.state", bus.state,       PLAY);
        chk("go.start", bus.start,       1);
        chk("go.lives", bus.lives,       3);
        chk("go.rr",    bus.round_reset, 1);
        chk("go.gr",    bus.game_reset,  1);
        bus.keycode = 8'h00;
        @(negedge Clk);
        #1;
        chk("go2.rr", bus.round_reset, 0);
        chk("go2.gr", bus.game_reset,  0);
        chk("go2.rr_cnt", rr_cnt, 1);
        chk("go2.gr_cnt", gr_cnt, 1);

        foreach (tbl[i]) begin
            bus.keycode = tbl[i].key;
            bus.gg      = tbl[i].gg;
            bus.sd_show = tbl[i].sd;
            bus.score   = tbl[i].score;
            repeat (tbl[i].clks) @(negedge Clk);
            pulse(tbl[i].frames);
            #1;
            chk($sformatf("v%0d.state", i),  bus.state,  tbl[i].st);
            chk($sformatf("v%0d.start", i),  bus.start,  tbl[i].start);
            chk($sformatf("v%0d.freeze", i), bus.freeze, tbl[i].freeze);
            chk($sformatf("v%0d.lives", i),  bus.lives,  tbl[i].lives);
            chk($sformatf("v%0d.ggShow", i), bus.ggShow, tbl[i].ggs);
            chk($sformatf("v%0d.win", i),    bus.win,    tbl[i].win);
            chk($sformatf("v%0d.rr_cnt", i), rr_cnt,     tbl[i].rr);
            chk($sformatf("v%0d.gr_cnt", i), gr_cnt,     tbl[i].gr);
        end

        // Async reset in the middle of a power phase (timer at 120).
        bus.keycode = 8'h28;
        bus.score   = 8'd0;
        bus.sd_show = 4'hF;
        @(negedge Clk);
        #1;
        bus.keycode = 8'h00;
        bus.sd_show = 4'hE;
        repeat (2) @(negedge Clk);
        pulse(179);
        #1;
        chk("pw.state", bus.state,  POWER);
        chk("pw.lives", bus.lives,  3);
        chk("pw.rr_cnt", rr_cnt, 6);
        chk("pw.gr_cnt", gr_cnt, 4);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("ar.state",  bus.state,  IDLE);
        chk("ar.start",  bus.start,  0);
        chk("ar.freeze", bus.freeze, 0);
        chk("ar.lives",  bus.lives,  3);
        chk("ar.win",    bus.win,    0);
        chk("ar.ggShow", bus.ggShow, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (4) @(negedge Clk);
        #1;
        chk("rel.state",  bus.state,  IDLE);
        chk("rel.start",  bus.start,  0);
        chk("rel.freeze", bus.freeze, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
